// File: rtl/display_pkg.sv
// Shared definitions for the HUB75 display scanner: scan states, pixel word
// layout helpers and the brightness width. Brightness scaling is enabled by
// defining DISPLAY_SCANNER_BRIGHTNESS_EN.
package display_pkg;

   // Scan sequence for one bit-plane of one row.
   typedef enum logic [2:0] {
      PREFETCH = 3'd0,
      SHIFT    = 3'd1,
      BLANK    = 3'd2,
      LATCH    = 3'd3,
      DISPLAY  = 3'd4
   } scan_state_t;

   // Cycles spent presenting the first read address before shifting starts.
   localparam int prefetch_cycles = 2;

   // Width of the global brightness control.
   localparam int brightness_w = 8;

   // Blue occupies the least significant field of a packed {r,g,b} word.
   localparam int blue_offset = 0;

   // Bits per colour channel in a packed pixel word.
   function automatic int channel_bits(input int word_width);
      return word_width / 3;
   endfunction

   // Bit offset of the red field inside a packed pixel word.
   function automatic int red_offset(input int word_width);
      return 2 * channel_bits(word_width);
   endfunction

   // Bit offset of the green field inside a packed pixel word.
   function automatic int green_offset(input int word_width);
      return channel_bits(word_width);
   endfunction

endpackage

// File: rtl/display_oe_timer.sv
// Bit-plane on-time timer. Loaded once per plane with the plane index (and,
// with DISPLAY_SCANNER_BRIGHTNESS_EN, the brightness), then counts while the
// scanner sits in DISPLAY. Reports when the panel may be lit and when the
// plane's display period has elapsed.
module display_oe_timer
   import display_pkg::*;
#(
   parameter int base_cycles = 8,
   parameter int plane_w     = 3,
   parameter int cnt_w       = 11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               run,
   input  logic [plane_w-1:0] plane,
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
   input  logic [brightness_w-1:0] brightness,
`endif
   output logic               oe_active,
   output logic               done
);

   logic [cnt_w-1:0] count;
   logic [cnt_w-1:0] duration;
   logic [cnt_w-1:0] on_limit;
   logic [cnt_w-1:0] duration_load;
   logic [cnt_w-1:0] limit_load;

   // Binary-code modulation: each plane is displayed twice as long as the previous one.
   assign duration_load = cnt_w'(base_cycles) << plane;

`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
   localparam int prod_w = cnt_w + brightness_w + 1;
   logic [prod_w-1:0] scaled;

   // Lit portion of the plane is duration * (brightness + 1) / 256, so 255 means fully on.
   assign scaled     = prod_w'(duration_load) * (prod_w'(brightness) + 1'b1);
   assign limit_load = cnt_w'(scaled >> brightness_w);
`else
   // Without brightness scaling the panel is lit for the whole display period.
   assign limit_load = duration_load;
`endif

   // Capture the plane's timing at load, then count display cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         duration <= '0;
         on_limit <= '0;
      end else if (load) begin
         count    <= '0;
         duration <= duration_load;
         on_limit <= limit_load;
      end else if (run) begin
         count <= count + 1'b1;
      end
   end

   assign oe_active = (count < on_limit);
   assign done      = (count == duration - 1'b1);

endmodule

// File: rtl/display_scanner.sv
// HUB75 display scanner. Reads the front buffer of the double-buffered display
// memory row by row and bit-plane by bit-plane, serialises the plane bits onto
// the panel shift interface and drives latch/OE with binary-code modulation.
// Owns the buffer select and swaps it only at a frame boundary.
// Optional global brightness: define DISPLAY_SCANNER_BRIGHTNESS_EN.
//
// Buffer swap handshake: flip_req is a level from the writer meaning "back
// buffer complete". It must stay high until flip_ack. The scanner samples it
// only in the last cycle of a frame; if high there, flip toggles and flip_ack
// pulses for exactly that cycle. A request seen at any other time waits.
module display_scanner
   import display_pkg::*;
#(
   parameter int segments    = 1,
   parameter int rows        = 8,
   parameter int columns     = 32,
   parameter int width       = 24,
   parameter int base_cycles = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flip_req,
   output logic                        flip,
   output logic                        flip_ack,
   output logic [$clog2(rows)-1:0]     rrow,
   output logic [$clog2(columns)-1:0]  rcol,
   input  logic [width*segments-1:0]   rdata,
   output logic                        display_clk,
   output logic                        display_latch,
   output logic                        display_oe,
   output logic [$clog2(rows)-1:0]     display_row,
   output logic [3*segments-1:0]       display_rgb,
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
   input  logic [brightness_w-1:0]     brightness,
`endif
   output logic [2:0]                  debug_state
);

   localparam int cb      = channel_bits(width);
   localparam int row_w   = $clog2(rows);
   localparam int col_w   = $clog2(columns);
   localparam int plane_w = $clog2(cb);
   localparam int step_w  = $clog2(2 * columns);
   localparam int cnt_w   = $clog2((base_cycles << (cb - 1)) + 1);
   localparam int r_off   = red_offset(width);
   localparam int g_off   = green_offset(width);

   localparam logic [row_w-1:0]   last_row      = row_w'(rows - 1);
   localparam logic [plane_w-1:0] last_plane    = plane_w'(cb - 1);
   localparam logic [col_w-1:0]   last_col      = col_w'(columns - 1);
   localparam logic [step_w-1:0]  shift_last    = step_w'(2 * columns - 1);
   localparam logic [step_w-1:0]  prefetch_last = step_w'(prefetch_cycles - 1);

   scan_state_t state, state_n;

   logic [row_w-1:0]      row, row_n;
   logic [plane_w-1:0]    plane, plane_n;
   logic [step_w-1:0]     step, step_n;
   logic [col_w-1:0]      shift_col;
   logic [3*segments-1:0] plane_rgb;

   logic                  flip_n, flip_ack_n;
   logic [row_w-1:0]      rrow_n;
   logic [col_w-1:0]      rcol_n;
   logic                  clk_n, latch_n, oe_n;
   logic [row_w-1:0]      display_row_n;
   logic [3*segments-1:0] rgb_n;

   logic timer_load, timer_run, timer_oe_active, timer_done;

   assign debug_state = state;

   // Column whose data arrives during the current shift step pair.
   assign shift_col = col_w'(step >> 1);

   // Select the current plane's r/g/b bits out of each segment's pixel word.
   for (genvar s = 0; s < segments; s++) begin : g_seg
      logic [cb-1:0] red_f, green_f, blue_f;
      assign red_f   = rdata[s*width + r_off +: cb];
      assign green_f = rdata[s*width + g_off +: cb];
      assign blue_f  = rdata[s*width + blue_offset +: cb];
      assign plane_rgb[3*s +: 3] = {red_f[plane], green_f[plane], blue_f[plane]};
   end

   display_oe_timer #(
      .base_cycles (base_cycles),
      .plane_w     (plane_w),
      .cnt_w       (cnt_w)
   ) u_oe_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .run        (timer_run),
      .plane      (plane),
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
      .brightness (brightness),
`endif
      .oe_active  (timer_oe_active),
      .done       (timer_done)
   );

   // State register: scan position and every registered panel/memory output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= PREFETCH;
         row           <= '0;
         plane         <= '0;
         step          <= '0;
         flip          <= 1'b0;
         flip_ack      <= 1'b0;
         rrow          <= '0;
         rcol          <= '0;
         display_clk   <= 1'b0;
         display_latch <= 1'b0;
         display_oe    <= 1'b1;
         display_row   <= '0;
         display_rgb   <= '0;
      end else begin
         state         <= state_n;
         row           <= row_n;
         plane         <= plane_n;
         step          <= step_n;
         flip          <= flip_n;
         flip_ack      <= flip_ack_n;
         rrow          <= rrow_n;
         rcol          <= rcol_n;
         display_clk   <= clk_n;
         display_latch <= latch_n;
         display_oe    <= oe_n;
         display_row   <= display_row_n;
         display_rgb   <= rgb_n;
      end
   end

   // Next-state: fixed-length prefetch/shift/blank/latch, timer-paced display.
   always_comb begin
      state_n = state;
      case (state)
         PREFETCH: if (step == prefetch_last) state_n = SHIFT;
         SHIFT:    if (step == shift_last)    state_n = BLANK;
         BLANK:    state_n = LATCH;
         LATCH:    state_n = DISPLAY;
         DISPLAY:  if (timer_done)            state_n = PREFETCH;
         default:  state_n = PREFETCH;
      endcase
   end

   // Outputs and scan position for the next cycle, per current state.
   always_comb begin
      step_n        = (state_n != state) ? '0 : step + 1'b1;
      row_n         = row;
      plane_n       = plane;
      flip_n        = flip;
      flip_ack_n    = 1'b0;
      rrow_n        = rrow;
      rcol_n        = rcol;
      clk_n         = display_clk;
      latch_n       = display_latch;
      oe_n          = display_oe;
      display_row_n = display_row;
      rgb_n         = display_rgb;
      timer_load    = 1'b0;
      timer_run     = 1'b0;

      case (state)
         PREFETCH: begin
            // Point memory at column 0 of this row; two cycles cover the read latency.
            rrow_n     = row;
            rcol_n     = '0;
            clk_n      = 1'b0;
            latch_n    = 1'b0;
            oe_n       = 1'b1;
            timer_load = (step == '0);
         end
         SHIFT: begin
            if (!step[0]) begin
               // Data for column shift_col has arrived; present it with the clock low.
               rgb_n  = plane_rgb;
               clk_n  = 1'b0;
               rcol_n = (shift_col == last_col) ? '0 : shift_col + 1'b1;
            end else begin
               clk_n = 1'b1;
            end
         end
         BLANK: begin
            clk_n = 1'b0;
            oe_n  = 1'b1;
         end
         LATCH: begin
            latch_n       = 1'b1;
            display_row_n = row;
         end
         DISPLAY: begin
            latch_n   = 1'b0;
            timer_run = 1'b1;
            oe_n      = ~timer_oe_active;
            if (timer_done) begin
               if (plane == last_plane) begin
                  plane_n = '0;
                  if (row == last_row) begin
                     // Frame boundary: the only point where the buffers may swap.
                     row_n = '0;
                     if (flip_req) begin
                        flip_n     = ~flip;
                        flip_ack_n = 1'b1;
                     end
                  end else begin
                     row_n = row + 1'b1;
                  end
               end else begin
                  plane_n = plane + 1'b1;
               end
            end
         end
         default: begin
            oe_n = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: synchronous memory model with two
// buffers, a per-cycle reference computed from the scan timing arithmetic,
// and literal checks on latch timing, OE widths, flip and async reset.
module tb_display_scanner;

   localparam int rows         = 8;
   localparam int columns      = 32;
   localparam int width        = 24;
   localparam int plane_fixed  = 2 + 2 * columns + 2;
   localparam int row_cycles   = 8 * plane_fixed + 8 * 255;
   localparam int frame_cycles = rows * row_cycles;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flip_req = 1'b0;
   logic        flip, flip_ack;
   logic [2:0]  rrow;
   logic [4:0]  rcol;
   logic [23:0] rdata = '0;
   logic        display_clk, display_latch, display_oe;
   logic [2:0]  display_row;
   logic [2:0]  display_rgb;
   logic [2:0]  debug_state;

   logic [23:0] mem [2][rows][columns];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_edge   = 0;
   int   phase    = 0;
   logic checking = 1'b0;

   // Reference state
   logic       model_flip;
   logic [2:0] model_rgb;
   logic [2:0] model_drow;
   int         low_run, run_idx, rise_cnt, rise_100, ack_cnt;
   logic       prev_clk;
   int         t, r, u, b, p, k, c;
   logic       exp_oe, exp_latch, exp_clk, exp_ack;
   int         exp_rcol;

   display_scanner dut (
      .clk           (clk),
      .rst           (rst),
      .flip_req      (flip_req),
      .flip          (flip),
      .flip_ack      (flip_ack),
      .rrow          (rrow),
      .rcol          (rcol),
      .rdata         (rdata),
      .display_clk   (display_clk),
      .display_latch (display_latch),
      .display_oe    (display_oe),
      .display_row   (display_row),
      .display_rgb   (display_rgb),
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
      .brightness    (8'd255),
`endif
      .debug_state   (debug_state)
   );

   // clock / memory model
   always #5 clk = ~clk;

   always @(posedge clk) rdata <= mem[flip][rrow][rcol];

   function automatic logic [2:0] plane_bits(input logic [23:0] w, input int bit_idx);
      return {w[16 + bit_idx], w[8 + bit_idx], w[bit_idx]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (phase %0d edge %0d)", name, act, exp, phase, n_edge);
      end
   endtask

   // reference model and per-cycle compare, sampled 1 time unit after each edge
   always @(posedge clk) begin
      #1;
      if (checking) begin
         t = n_edge % frame_cycles;
         r = t / row_cycles;
         u = t % row_cycles;
         b = 0;
         while (u >= plane_fixed + (8 << b)) begin
            u = u - (plane_fixed + (8 << b));
            b++;
         end
         p = u;
         exp_ack   = 1'b0;
         exp_clk   = 1'b0;
         exp_latch = 1'b0;
         exp_oe    = 1'b1;
         exp_rcol  = 0;
         if (p >= 2 && p < 2 + 2 * columns) begin
            k = p - 2;
            c = k / 2;
            exp_rcol = (c + 1) % columns;
            if (k % 2 == 0) model_rgb = plane_bits(mem[model_flip][r][c], b);
            else            exp_clk = 1'b1;
         end else if (p == 2 * columns + 3) begin
            exp_latch  = 1'b1;
            model_drow = 3'(r);
         end else if (p >= plane_fixed) begin
            exp_oe = 1'b0;
         end
         if (t == frame_cycles - 1 && flip_req) begin
            model_flip = ~model_flip;
            exp_ack    = 1'b1;
         end

         check("display_oe",    display_oe,    exp_oe);
         check("display_latch", display_latch, exp_latch);
         check("display_clk",   display_clk,   exp_clk);
         check("display_rgb",   display_rgb,   model_rgb);
         check("display_row",   display_row,   model_drow);
         check("rrow",          rrow,          r);
         check("rcol",          rcol,          exp_rcol);
         check("flip",          flip,          model_flip);
         check("flip_ack",      flip_ack,      exp_ack);

         // hand-computed expectations
         if (flip_ack) ack_cnt++;
         if (display_clk && !prev_clk && n_edge < plane_fixed) begin
            rise_cnt++;
            if (display_rgb == 3'b100) rise_100++;
         end
         prev_clk = display_clk;
         if (display_oe == 1'b0) begin
            low_run++;
         end else if (low_run > 0) begin
            if ((phase == 0 || phase == 3) && run_idx == 0) check("oe_low_plane0", low_run, 8);
            if ((phase == 0 || phase == 3) && run_idx == 7) check("oe_low_plane7", low_run, 1024);
            run_idx++;
            low_run = 0;
         end
         if ((phase == 0 || phase == 3) && n_edge == 0) begin
            check("state_after_release", debug_state, 0);
            check("oe_after_release", display_oe, 1);
         end
         if ((phase == 0 || phase == 3) && n_edge == 66) check("no_latch_at_66", display_latch, 0);
         if ((phase == 0 || phase == 3) && n_edge == 67) begin
            check("first_latch_67", display_latch, 1);
            check("rising_clk_per_plane", rise_cnt, 32);
            check("rgb_100_on_rise", rise_100, 32);
         end
         if (phase == 0 && n_edge == 3 * row_cycles + 67) begin
            check("row3_latch", display_latch, 1);
            check("row3_display_row", display_row, 3);
         end
         if (phase == 0 && n_edge == frame_cycles + 8) check("no_flip_without_req", flip, 0);
         if (phase == 1 && n_edge == frame_cycles - 1) begin
            check("flip_at_20671", flip, 1);
            check("flip_ack_at_20671", flip_ack, 1);
         end
         if (phase == 1 && n_edge == frame_cycles + 2) check("new_buffer_rgb", display_rgb, 3'b010);
         n_edge++;
      end
   end

   // driver tasks
   task automatic start_phase(input int ph);
      model_flip = 1'b0;
      model_rgb  = '0;
      model_drow = '0;
      low_run    = 0;
      run_idx    = 0;
      rise_cnt   = 0;
      rise_100   = 0;
      ack_cnt    = 0;
      prev_clk   = 1'b0;
      phase      = ph;
      @(negedge clk);
      rst      = 1'b0;
      n_edge   = 0;
      checking = 1'b1;
   endtask

   task automatic stop_and_reset();
      @(negedge clk);
      checking = 1'b0;
      rst      = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bit got_ack;
      for (int rr = 0; rr < rows; rr++) begin
         for (int cc = 0; cc < columns; cc++) begin
            mem[0][rr][cc] = (rr == 0) ? 24'hFF0000 : {8'(rr * 16 + cc), 8'(cc * 7), 8'(rr ^ cc)};
            mem[1][rr][cc] = {8'(cc * 5 + rr), ~8'(cc), 8'(rr * 33 + cc)};
         end
      end
      repeat (3) @(negedge clk);

      // phase 0: free-running frame with no swap request
      start_phase(0);
      repeat (frame_cycles + 20) @(negedge clk);
      stop_and_reset();

      // phase 1: request a swap at cycle 100, expect it at the frame boundary
      start_phase(1);
      repeat (100) @(negedge clk);
      flip_req = 1'b1;
      got_ack  = 1'b0;
      for (int i = 0; i < frame_cycles + 100 && !got_ack; i++) begin
         @(negedge clk);
         if (flip_ack) got_ack = 1'b1;
      end
      check("flip_ack_seen", got_ack, 1);
      flip_req = 1'b0;
      repeat (3000) @(negedge clk);
      check("flip_ack_count", ack_cnt, 1);
      stop_and_reset();

      // phase 2: asynchronous reset during plane 5 DISPLAY of row 0
      start_phase(2);
      repeat (701) @(negedge clk);
      checking = 1'b0;
      check("oe_low_before_reset", display_oe, 0);
      check("rgb_before_reset", display_rgb, 3'b100);
      #2;
      rst = 1'b1;
      #1;
      check("reset_oe", display_oe, 1);
      check("reset_latch", display_latch, 0);
      check("reset_clk", display_clk, 0);
      check("reset_rgb", display_rgb, 0);
      check("reset_row", display_row, 0);
      check("reset_rrow", rrow, 0);
      check("reset_rcol", rcol, 0);
      check("reset_flip", flip, 0);
      check("reset_flip_ack", flip_ack, 0);
      check("reset_state", debug_state, 0);
      repeat (3) @(negedge clk);

      // phase 3: scan restarts at row 0 plane 0
      start_phase(3);
      repeat (2700) @(negedge clk);
      checking = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scanner.md
# display_scanner

Downstream consumer of the double-buffered display memory. Walks the front buffer row by row and bit-plane by bit-plane, issuing `rrow`/`rcol` reads and turning the returned 24-bit RGB words into HUB75-style serial panel signals (shift clock, latch, output enable, row address, RGB bits) with binary-code modulation (BCM). It also owns the buffer `flip`, swapping buffers only at a frame boundary when the upstream writer requests it.

## Interface
- `segments`, 1, panel segments driven in parallel; one RGB triple per segment
- `rows`, 8, scan rows per segment
- `columns`, 32, pixels per row
- `width`, 24, bits per pixel word, packed `{r,g,b}`, `width/3` bits per channel
- `base_cycles`, 8, OE on-time of bit-plane 0 in `clk` cycles
- `clk` in 1: single system clock
- `rst` in 1: reset, asynchronous, active-high
- `flip_req` in 1: level; back buffer complete, swap requested; held until `flip_ack`
- `flip` out 1: buffer select to display memory
- `flip_ack` out 1: one-cycle pulse in the cycle `flip` toggles
- `rrow` out `$clog2(rows)`: memory read row
- `rcol` out `$clog2(columns)`: memory read column
- `rdata` in `width*segments`: memory read data, valid one cycle after `rrow`/`rcol`
- `display_clk` out 1: panel shift clock, data sampled on rising edge
- `display_latch` out 1: panel latch, active-high
- `display_oe` out 1: panel output enable, active-low
- `display_row` out `$clog2(rows)`: panel row address
- `display_rgb` out `3*segments`: segment s drives `[3s+2:3s]` = `{r,g,b}` bit
- `brightness` in 8: global brightness (only with `DISPLAY_SCANNER_BRIGHTNESS_EN`)

## Operation
- All outputs registered. Reset values: `flip`=0, `flip_ack`=0, `rrow`=0, `rcol`=0, `display_clk`=0, `display_latch`=0, `display_oe`=1, `display_row`=0, `display_rgb`=0; state PREFETCH, row 0, plane 0.
- Order: row 0..rows-1 outer, plane 0..`width/3`-1 inner. Plane b of channel uses bit b of r, g, b fields of segment slice `rdata[s*width +: width]`.
- PREFETCH (2 cycles): `rrow`=current row, `rcol`=0, `display_oe`=1.
- SHIFT (2*columns cycles, k=0..): even k=2c: `display_rgb` <= plane bits of `rdata` (column c), `display_clk` <= 0, `rcol` <= c+1 (wraps to 0 after last column); odd k: `display_clk` <= 1.
- BLANK (1 cycle): `display_clk` <= 0, `display_oe` stays 1.
- LATCH (1 cycle): `display_latch` <= 1, `display_row` <= current row.
- DISPLAY (`base_cycles << b` cycles): `display_latch` <= 0, `display_oe` <= 0; on exit `display_oe` <= 1, advance plane, then row.
- Frame boundary (exit of DISPLAY, last plane, last row): if `flip_req`=1, toggle `flip` and pulse `flip_ack` the same cycle; next PREFETCH reads new buffer. `flip_req`=0: no toggle, old buffer rescanned.
- `flip_req` asserted mid-frame: ignored until boundary; never toggles mid-frame.
- Reset mid-frame: asynchronous; `display_oe` goes high immediately, all outputs/state to reset values.

## Timing
- Memory read latency: 1 cycle; `rcol` updated at k=2c, visible k=2c+1, `rdata` valid k=2c+2.
- Cycles per plane b: 2 + 2*columns + 1 + 1 + (`base_cycles << b`).
- Defaults: row = 8*68 + 8*255 = 2584 cycles; frame = 20672 cycles.
- Panel shift clock = `clk`/2, 50% duty.
- OE never low during PREFETCH, SHIFT, BLANK, LATCH.

## Configuration
- `DISPLAY_SCANNER_BRIGHTNESS_EN` defined: `brightness` port exists; in DISPLAY, `display_oe`=0 only while on-counter < ((`base_cycles << b`) * (`brightness`+1)) >> 8; DISPLAY duration unchanged. `brightness` sampled at PREFETCH of each plane.
- Undefined: no `brightness` port; OE low for whole DISPLAY.

## Structure
- Package `display_pkg`: scanner state enum (PREFETCH, SHIFT, BLANK, LATCH, DISPLAY), `channel_bits = width/3` helper, pixel field offsets.
- Sub-module `display_oe_timer`: loads plane index (and brightness), counts DISPLAY duration, drives OE-active and done.

## Test plan
- Reset, release, no flip_req -> `display_oe`=1 for first 68 cycles; first latch at cycle 67; first OE-low 8 cycles; `flip` stays 0 after 20672 cycles.
- Memory model col c = 0xFF0000 at plane 0 -> `display_rgb`=3'b100 each rising `display_clk`, 32 rising edges per plane.
- `flip_req`=1 at cycle 100 -> `flip` toggles and `flip_ack` pulses exactly once at cycle 20671; rrow/rcol reads thereafter from new buffer.
- Plane 7 -> OE low for 1024 cycles; row 3 latch -> `display_row`=3.
- Assert `rst` during plane-5 DISPLAY -> `display_oe`=1 same cycle, all outputs reset, scan restarts row 0 plane 0.
- With macro, `brightness`=127 -> plane 7 OE low 512 of 1024 cycles; `brightness`=255 -> full 1024.
